serial_add_sched: RTL and testbench

//  Bit-serial adder scheduler: shares one 1-bit full-adder cell (two half-adder cells + OR) among

---
 rtl/serial_add_sched_pkg.sv | 18 +
 rtl/serial_add_sched_if.sv | 30 +++
 rtl/serial_add_sched_half_adder_cell.sv | 12 +
 rtl/serial_add_sched.sv | 153 +++++++++++++++
 tb/tb_serial_add_sched.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_sched_pkg.sv
// Shared types and defaults for the bit-serial adder scheduler.
package serial_add_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NREQ_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Requester index visited at step k of a round-robin search starting at base.
  function automatic int rr_index(input int base, input int k, input int n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/serial_add_sched_if.sv
// Request/response bundle between operand requesters and the serial adder scheduler.
interface serial_add_sched_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2
) ();
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;

  // Requester / result-consumer side.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

endinterface

// File: rtl/serial_add_sched_half_adder_cell.sv
// One-bit half adder; two of these plus an OR form the shared full-adder cell.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_sched.sv
// Bit-serial adder scheduler: round-robin grants one requester at a time and
// adds its operands LSB-first through a single shared full-adder cell.
module serial_add_sched
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_sched_if.slave  bus,
  output logic               busy
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant_id;
  logic             grant_vld;
  logic [NREQ-1:0]  grant_oh;
  logic             accept;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic [CNT_W-1:0] cnt;
  logic             cin;
  logic             carry_r;
  logic [ID_W-1:0]  id_r;

  logic s1, c1, sum_bit, c2, cout;

  // Round-robin search: first valid requester at or after rr_ptr wins.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    grant_oh  = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_index(int'(rr_ptr), k, NREQ);
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
    if (grant_vld) grant_oh[grant_id] = 1'b1;
  end

  // A grant is only honoured in IDLE and never during the reset cycle.
  assign accept = (state == IDLE) && !rst && grant_vld;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the MSB, DONE -> IDLE on handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)            state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST)   state_nxt = DONE;
      DONE:    if (bus.rsp_ready)     state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Control outputs decoded from the current state.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && !rst) bus.req_ready = grant_oh;
    bus.rsp_valid = (state == DONE);
    busy          = (state != IDLE);
  end

  // Round-robin pointer moves past the requester just accepted, wrapping to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      if (int'(grant_id) == NREQ - 1) rr_ptr <= '0;
      else                            rr_ptr <= grant_id + ID_W'(1);
    end
  end

  // Shared full-adder cell: two half adders, carry-out OR kept here.
  half_adder_cell u_ha_ab (
    .a (a_sr[0]),
    .b (b_sr[0]),
    .s (s1),
    .c (c1)
  );

  half_adder_cell u_ha_cin (
    .a (s1),
    .b (cin),
    .s (sum_bit),
    .c (c2)
  );

  assign cout = c1 | c2;

  // Operand shift registers: captured on accept, shifted right so bit cnt sits at bit 0.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sr <= bus.req_a[int'(grant_id)*WIDTH +: WIDTH];
      b_sr <= bus.req_b[int'(grant_id)*WIDTH +: WIDTH];
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
    end
  end

  // Bit counter, carry chain, sum assembly and result id; counter parks at WIDTH-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      cin     <= 1'b0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      id_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt  <= '0;
            cin  <= 1'b0;
            id_r <= grant_id;
          end
        end
        RUN: begin
          sum_r[cnt] <= sum_bit;
          cin        <= cout;
          if (cnt == CNT_LAST) carry_r <= cout;
          else                 cnt     <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_sum   = sum_r;
  assign bus.rsp_carry = carry_r;
  assign bus.rsp_id    = id_r;

endmodule

// File: tb/tb_serial_add_sched.sv
// Self-checking bench for serial_add_sched (WIDTH=8, NREQ=2).
module tb_serial_add_sched;
  import serial_add_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREQ  = 2;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  serial_add_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  serial_add_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int model_ptr = 0;

  typedef struct {
    logic [1:0] mask;
    logic [7:0] a0, b0, a1, b1;
    int         exp_id;
    logic [7:0] exp_sum;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbiter: first valid requester at or after the model pointer.
  function automatic int model_grant(input logic [1:0] mask);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (model_ptr + k) % NREQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_ptr = 0;
  endtask

  // One full operation: offer, accept, wait for result, optional stall, handshake.
  task automatic do_op(input string nm, input logic [1:0] mask,
                       input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1,
                       input int exp_id, input logic [7:0] es, input logic ec,
                       input int stall);
    int lat;
    bus.req_a     = {a1, a0};
    bus.req_b     = {b1, b0};
    bus.req_valid = mask;
    bus.rsp_ready = 1'b0;
    #1;
    check({nm, " grant"}, bus.req_ready, 32'(1 << exp_id));
    tick();
    bus.req_valid = '0;
    bus.req_a     = 16'($urandom);
    bus.req_b     = 16'($urandom);
    model_ptr     = (exp_id + 1) % NREQ;
    check({nm, " ready/busy in run"}, {bus.req_ready, busy}, 32'b001);
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check({nm, " latency"}, lat, WIDTH);
    check({nm, " sum"}, bus.rsp_sum, es);
    check({nm, " carry"}, bus.rsp_carry, ec);
    check({nm, " id"}, bus.rsp_id, exp_id);
    if (stall > 0) begin
      bus.req_valid = 2'b11;
      repeat (stall) tick();
      check({nm, " stall valid/busy/ready"}, {bus.rsp_valid, busy, bus.req_ready}, 32'b1100);
      check({nm, " stall sum/carry"}, {bus.rsp_carry, bus.rsp_sum}, {23'd0, ec, es});
      bus.req_valid = '0;
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({nm, " release"}, {bus.rsp_valid, busy}, 32'b00);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    rst           = 1'b1;

    // Reset state, with requests pending during reset.
    bus.req_valid = 2'b11;
    tick();
    tick();
    check("reset req_ready", bus.req_ready, 32'b00);
    check("reset busy/valid", {busy, bus.rsp_valid}, 32'b00);
    check("reset sum/carry/id", {bus.rsp_id, bus.rsp_carry, bus.rsp_sum}, 32'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    model_ptr = 0;
    tick();

    // Directed vectors (pointer sequence from reset: 0,1,1,1,0,1,0,0).
    vecs[0] = '{2'b01, 8'h0F, 8'h01, 8'h00, 8'h00, 0, 8'h10, 1'b0};
    vecs[1] = '{2'b01, 8'hFF, 8'h01, 8'h00, 8'h00, 0, 8'h00, 1'b1};
    vecs[2] = '{2'b01, 8'hAA, 8'h55, 8'h00, 8'h00, 0, 8'hFF, 1'b0};
    vecs[3] = '{2'b10, 8'h00, 8'h00, 8'h80, 8'h80, 1, 8'h00, 1'b1};
    vecs[4] = '{2'b11, 8'h12, 8'h34, 8'h77, 8'h77, 0, 8'h46, 1'b0};
    vecs[5] = '{2'b11, 8'h99, 8'h99, 8'hFF, 8'hFF, 1, 8'hFE, 1'b1};
    vecs[6] = '{2'b10, 8'h00, 8'h00, 8'h7F, 8'h01, 1, 8'h80, 1'b0};
    vecs[7] = '{2'b01, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 1'b0};
    vecs[8] = '{2'b01, 8'h01, 8'h01, 8'h00, 8'h00, 0, 8'h02, 1'b0};
    for (int i = 0; i < 9; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].mask, vecs[i].a0, vecs[i].b0,
            vecs[i].a1, vecs[i].b1, vecs[i].exp_id, vecs[i].exp_sum,
            vecs[i].exp_carry, i % 3);
    end

    // Operands changed mid-operation must not affect the latched values.
    bus.req_a = 16'h0001;
    bus.req_b = 16'h0001;
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = '0;
    bus.req_a = 16'h00F0;
    repeat (WIDTH) tick();
    check("latched operands sum", {bus.rsp_valid, bus.rsp_carry, bus.rsp_sum}, {22'd0, 1'b1, 1'b0, 8'h02});
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    model_ptr = 1;

    // Back-to-back with both requesters valid: alternating grants every WIDTH+2 cycles.
    do_reset();
    begin
      int n, last, eg;
      n = 0;
      last = -1;
      bus.req_a = {8'h10, 8'h03};
      bus.req_b = {8'h20, 8'h04};
      bus.req_valid = 2'b11;
      bus.rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 80 && n < 4; cyc++) begin
        tick();
        if (bus.rsp_valid === 1'b1) begin
          eg = model_ptr;
          model_ptr = (eg + 1) % NREQ;
          check($sformatf("b2b%0d id", n), bus.rsp_id, eg);
          check($sformatf("b2b%0d sum", n), bus.rsp_sum, (eg == 1) ? 32'h30 : 32'h07);
          if (last >= 0) check($sformatf("b2b%0d interval", n), cyc - last, WIDTH + 2);
          last = cyc;
          n++;
        end
      end
      bus.req_valid = '0;
      check("b2b response count", n, 4);
      tick();
      bus.rsp_ready = 1'b0;
      tick();
    end

    // Reset in the middle of RUN discards the operation and rewinds the pointer.
    begin
      int seen;
      seen = 0;
      bus.req_a = {8'h00, 8'h11};
      bus.req_b = {8'h00, 8'h22};
      bus.req_valid = 2'b01;
      tick();
      bus.req_valid = '0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_ptr = 0;
      check("mid-run reset busy/valid", {busy, bus.rsp_valid}, 32'b00);
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
        tick();
        if (bus.rsp_valid !== 1'b0) seen++;
      end
      bus.rsp_ready = 1'b0;
      check("no response after abort", seen, 0);
      do_op("post-reset rr", 2'b11, 8'h05, 8'h06, 8'h40, 8'h40, 0, 8'h0B, 1'b0, 0);
    end

    // Randomized operations against the arithmetic / round-robin model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] mask;
      logic [7:0] a0, b0, a1, b1, ea, eb;
      logic [8:0] s9;
      int g;
      if (i % 5 == 0) begin
        bus.req_valid = '0;
        #1;
        check($sformatf("rnd%0d idle", i), {bus.req_ready, busy}, 32'b000);
        tick();
      end
      mask = 2'($urandom_range(1, 3));
      a0 = 8'($urandom); b0 = 8'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom);
      g  = model_grant(mask);
      ea = (g == 1) ? a1 : a0;
      eb = (g == 1) ? b1 : b0;
      s9 = {1'b0, ea} + {1'b0, eb};
      do_op($sformatf("rnd%0d", i), mask, a0, b0, a1, b1, g, s9[7:0], s9[8],
            int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
